// File: rtl/bk_serial_sub_decoder.sv
// Recovers operand B from a Brent-Kung adder result and the known operand A,
// subtracting DIGIT bits per cycle along a serial borrow chain.
module bk_serial_sub_decoder #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_result,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
      $error("bk_serial_sub_decoder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_b_q, out_b_d;
  logic               out_err_q, out_err_d;
  logic [DIGIT:0]     dig;
  logic [WIDTH-1:0]   b_nxt;

  // One digit of the borrow chain; bit DIGIT of the result is the borrow-out.
  function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] r,
                                               input logic [DIGIT-1:0] a,
                                               input logic             bin);
    sub_digit = {1'b0, r} - {1'b0, a} - {{DIGIT{1'b0}}, bin};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      res_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      out_b_q   <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      out_b_q   <= out_b_d;
      out_err_q <= out_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    out_b_d   = out_b_q;
    out_err_d = out_err_q;
    dig       = sub_digit(res_q[DIGIT-1:0], a_q[DIGIT-1:0], borrow_q);
    // New digits enter at the top so B is fully aligned after NDIG shifts.
    b_nxt     = WIDTH'({dig[DIGIT-1:0], b_q} >> DIGIT);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d    = in_result[WIDTH-1:0];
          carry_d  = in_result[WIDTH];
          a_d      = in_a;
          b_d      = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = res_q >> DIGIT;
        a_d      = a_q >> DIGIT;
        b_d      = b_nxt;
        borrow_d = dig[DIGIT];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          // Carry-out and final borrow cancel only when the difference fits.
          out_b_d   = b_nxt;
          out_err_d = carry_q ^ dig[DIGIT];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_b     = out_b_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bk_serial_sub_decoder.sv
// Randomized round-trip bench for bk_serial_sub_decoder against an
// integer-arithmetic reference of B = result - A.
module tb_bk_serial_sub_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_result;
  logic [11:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_b;
  logic        out_err;

  int n_cmp;
  int n_mis;

  bk_serial_sub_decoder #(.WIDTH(12), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; stimulus and sampling both happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ref_model(input logic [12:0] r, input logic [11:0] a,
                           output logic [11:0] eb, output logic ee);
    int diff;
    logic [31:0] wrapped;
    diff    = int'(r) - int'(a);
    wrapped = diff;
    eb      = wrapped[11:0];
    ee      = (diff < 0) || (diff > 4095);
  endtask

  task automatic do_req(input logic [12:0] r, input logic [11:0] a, input int stall);
    logic [11:0] eb;
    logic        ee;
    int          lat;
    ref_model(r, a, eb, ee);
    lat = 0;
    while (!in_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_result = r;
    in_a      = a;
    out_ready = (stall == 0);
    tick();
    // Inputs after acceptance must not influence the computation.
    in_valid  = 1'b0;
    in_result = 13'($urandom);
    in_a      = 12'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency_cycles", lat, 4);
    check("out_b", out_b, eb);
    check("out_err", out_err, ee);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        in_valid  = 1'($urandom);
        in_result = 13'($urandom);
        in_a      = 12'($urandom);
        tick();
        check("stall_out_valid", out_valid, 1);
        check("stall_out_b", out_b, eb);
        check("stall_out_err", out_err, ee);
        check("stall_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_b_kept", out_b, eb);
    check("post_hs_out_err_kept", out_err, ee);
    out_ready = 1'($urandom);
  endtask

  initial begin
    logic [12:0] r;
    logic [11:0] a;
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_a      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end

    do_req(13'h0_91A, 12'h123, 0);
    do_req(13'h1_FFE, 12'hFFF, 0);
    do_req(13'h0_005, 12'h006, 0);
    do_req(13'h1_005, 12'h004, 0);
    do_req(13'h0_91A, 12'h123, 5);

    // Reset during the second RUN cycle discards the request.
    in_valid  = 1'b1;
    in_result = 13'h1_FFF;
    in_a      = 12'h001;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_b", out_b, 0);
    check("midrst_out_err", out_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_out_valid", out_valid, 0);
    do_req(13'h0_002, 12'h001, 0);

    for (int n = 0; n < 150; n++) begin
      a = 12'($urandom);
      case ($urandom_range(0, 3))
        0: r = 13'($urandom);
        1: r = {1'b0, a} + 13'($urandom_range(0, 4095));
        2: r = {1'b0, a} - 13'($urandom_range(0, 2));
        default: r = {1'b1, 12'($urandom_range(0, 3))};
      endcase
      do_req(r, a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bk_serial_sub_decoder.md
Name: bk_serial_sub_decoder

Overview:
- Inverse of the team's 12-bit Brent-Kung adder.
- Takes a 13-bit adder result (sum plus carry-out) and the known operand A. Recovers operand B = result − A using a digit-serial borrow-chain subtractor.
- Sits downstream of the adder in self-checking/round-trip datapaths. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 12, operand width; the result input is WIDTH+1 bits.
- DIGIT, 4, bits subtracted per cycle; WIDTH must be a multiple of DIGIT (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request holds a valid result/operand pair.
- in_ready  output  1  block can accept a request.
- in_result  input  WIDTH+1  adder output; bit WIDTH is the carry-out.
- in_a  input  WIDTH  known operand A.
- out_valid  output  1  out_b/out_err valid.
- out_ready  input  1  consumer accepts the output.
- out_b  output  WIDTH  recovered operand B = (in_result − in_a) mod 2^WIDTH.
- out_err  output  1  set when in_result − in_a lies outside [0, 2^WIDTH−1].

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - state=IDLE, in_ready=1, out_valid=0, out_b=0, out_err=0.
  - Internal borrow=0, digit counter=0, operand/result shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_result and in_a, clear borrow and counter, go to RUN.
  - in_ready drops the next cycle.
- RUN:
  - in_ready=0.
  - Each cycle subtract the low DIGIT bits: d = r_lo − a_lo − borrow, computed (DIGIT+1) bits wide.
  - The low DIGIT bits of d fill the top of the B shift register. borrow ← d[DIGIT].
  - Operand registers shift right by DIGIT. Counter increments.
  - After WIDTH/DIGIT cycles (3 at defaults), go to DONE.
- DONE entry:
  - out_b = assembled B.
  - out_err = captured result bit WIDTH XOR final borrow.
    - Carry=0 with borrow=1: result < A (underflow).
    - Carry=1 with borrow=0: B ≥ 2^WIDTH (overflow).
  - out_valid=1.
- DONE:
  - out_valid held; out_b/out_err stable while out_valid&!out_ready.
  - On out_ready, go to IDLE (out_valid=0, in_ready=1 the following cycle).
  - out_b/out_err retain their last value after the handshake.
- Latency: accept edge to out_valid rising = WIDTH/DIGIT + 1 cycles (4 at defaults). Throughput is one request per WIDTH/DIGIT + 2 cycles with out_ready held high.
- in_valid while not in_ready is ignored. The request is not queued, and in_result/in_a changes during RUN/DONE have no effect.
- out_ready asserted outside DONE has no effect.
- rst_n asserted mid-RUN or mid-DONE: immediate return to the reset values above. The partial result is discarded and no out_valid pulse is emitted.
- All arithmetic is unsigned. No combinational path from in_* to out_*.
- in_ready is purely a function of state, so it does not depend on out_ready.

Test Plan:
- Reset check: hold rst_n=0 → in_ready=1, out_valid=0, out_b=0, out_err=0. Release rst_n; state stays IDLE with no spurious out_valid.
- Nominal round-trip: in_result=0x0_91A (0x123+0x7F7 = 0x91A, carry 0), in_a=0x123, out_ready=1 → out_valid 4 cycles after accept, out_b=0x7F7, out_err=0. Next accept possible 1 cycle after the output handshake.
- Carry-out case: in_result=0x1_FFE (0xFFF+0xFFF), in_a=0xFFF → out_b=0xFFF, out_err=0. Carry bit absorbed by the final borrow.
- Error cases:
  - in_result=0x0_005, in_a=0x006 → out_b=0xFFF, out_err=1 (underflow).
  - in_result=0x1_005, in_a=0x004 → out_b=0x001, out_err=1 (overflow).
- Backpressure: complete a request with out_ready=0 for 5 cycles → out_valid stays 1, out_b constant, in_ready=0 throughout. Toggling in_valid/in_result during the stall does not alter the output. Raising out_ready completes the handshake in that cycle.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle → outputs return to reset values immediately. A new request after release (0x0_002, in_a=0x001) yields out_b=0x001, out_err=0, with no stale borrow.
